// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Word-addressed data RAM that answers CPU load/store requests with a fixed,
//   parameterised latency. A request is latched in IDLE, optionally held in
//   WAIT for WAIT_STATES cycles, and answered with a one-cycle DataReady pulse
//   in RESP. Out-of-range addresses and simultaneous read+write complete with
//   normal timing and DataError=1.
//
//   Optional feature (macro DMEM_CYCLE_COUNTER_EN): a 32-bit free-running
//   cycle counter mapped at word address 32'hFFFF_FFF0, readable and writable.
//   Without the macro that address is simply out of range.
//
// Parameters
//   DEPTH        RAM size in 32-bit words (power of two)
//   WAIT_STATES  extra cycles (0-15) before each response
//
// Ports
//   clock      in   sole clock, rising edge
//   reset      in   synchronous, active-high
//   DataAddr   in   [31:0] word address from CPU
//   DataOut    in   [31:0] write data from CPU
//   DataRead   in   read request, held until DataReady
//   DataWrite  in   write request, held until DataReady
//   DataIn     out  [31:0] registered read data
//   DataReady  out  one-cycle response strobe
//   DataError  out  error flag, meaningful with DataReady
module data_mem_responder #(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] DataAddr,
  input  logic [31:0] DataOut,
  input  logic        DataRead,
  input  logic        DataWrite,
  output logic [31:0] DataIn,
  output logic        DataReady,
  output logic        DataError
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WS_M1 = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
`ifdef DMEM_CYCLE_COUNTER_EN
  localparam logic [31:0] CNT_ADDR = 32'hFFFF_FFF0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state_q;
  logic [3:0]  wcnt_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        rd_q;
  logic        wr_q;
  logic [31:0] mem_q [DEPTH];
  logic [31:0] cycle_q;

  // The request being serviced: taken straight from the inputs while IDLE
  // (so a zero-wait response can be formed on the sampling edge), otherwise
  // from the latched copy.
  logic [31:0] cur_addr;
  logic        cur_rd;
  logic        cur_wr;
  logic        req;
  logic        in_ram;
  logic        is_cnt;
  logic        acc_err;
  logic        do_rd;
  logic        do_wr;
  logic        enter_resp;
  logic [31:0] rd_val;

  always_comb begin
    cur_addr = (state_q == S_IDLE) ? DataAddr  : addr_q;
    cur_rd   = (state_q == S_IDLE) ? DataRead  : rd_q;
    cur_wr   = (state_q == S_IDLE) ? DataWrite : wr_q;
    req      = DataRead | DataWrite;
    in_ram   = (cur_addr < 32'(DEPTH));
`ifdef DMEM_CYCLE_COUNTER_EN
    is_cnt   = (cur_addr == CNT_ADDR);
`else
    is_cnt   = 1'b0;
`endif
    // Conflicting strobes never touch storage; unmapped addresses flag error.
    acc_err  = (cur_rd & cur_wr) | ~(in_ram | is_cnt);
    // An out-of-range read still loads (zero); a conflict loads nothing.
    do_rd    = cur_rd & ~cur_wr;
    do_wr    = cur_wr & ~cur_rd & ~acc_err;
    rd_val   = 32'd0;
    if (in_ram) begin
      rd_val = mem_q[cur_addr[AW-1:0]];
    end else if (is_cnt) begin
      rd_val = cycle_q;
    end
    enter_resp = ((state_q == S_IDLE) && req && (WAIT_STATES == 0)) ||
                 ((state_q == S_WAIT) && (wcnt_q == 4'd0));
  end

  // Control FSM with registered response outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      wcnt_q    <= 4'd0;
      DataIn    <= 32'd0;
      DataReady <= 1'b0;
      DataError <= 1'b0;
    end else begin
      DataReady <= 1'b0;
      DataError <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req) begin
            if (WAIT_STATES > 0) begin
              state_q <= S_WAIT;
              wcnt_q  <= WS_M1;
            end else begin
              state_q <= S_RESP;
            end
          end
        end
        S_WAIT: begin
          if (wcnt_q == 4'd0) begin
            state_q <= S_RESP;
          end else begin
            wcnt_q <= wcnt_q - 4'd1;
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
      if (enter_resp) begin
        DataReady <= 1'b1;
        DataError <= acc_err;
        if (do_rd) begin
          DataIn <= rd_val;
        end
      end
    end
  end

  // Request capture (data path, not reset).
  always_ff @(posedge clock) begin
    if ((state_q == S_IDLE) && req) begin
      addr_q  <= DataAddr;
      wdata_q <= DataOut;
      rd_q    <= DataRead;
      wr_q    <= DataWrite;
    end
  end

  // Writes commit on the edge leaving RESP; a reset on that edge abandons
  // the store. RAM contents themselves are never cleared.
  always_ff @(posedge clock) begin
    if (!reset && (state_q == S_RESP) && do_wr && in_ram) begin
      mem_q[addr_q[AW-1:0]] <= wdata_q;
    end
  end

`ifdef DMEM_CYCLE_COUNTER_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      cycle_q <= 32'd0;
    end else if ((state_q == S_RESP) && do_wr && is_cnt) begin
      cycle_q <= wdata_q;
    end else begin
      cycle_q <= cycle_q + 32'd1;
    end
  end
`else
  assign cycle_q = 32'd0;
`endif

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning data RAM size in 32-bit words (word-addressed, power of two).
REQ-002 SHALL have parameter WAIT_STATES, default 1, meaning extra cycles (0-15) inserted before each response.
REQ-003 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port DataAddr  input  32  word address from CPU.
REQ-006 SHALL have port DataOut  input  32  write data from CPU.
REQ-007 SHALL have port DataRead  input  1  read request, held by CPU until DataReady.
REQ-008 SHALL have port DataWrite  input  1  write request, held by CPU until DataReady.
REQ-009 SHALL have port DataIn  output  32  registered read data to CPU.
REQ-010 SHALL have port DataReady  output  1  one-cycle response strobe.
REQ-011 SHALL have port DataError  output  1  error flag, valid only with DataReady.

Function
REQ-012 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-013 IDLE: on DataRead or DataWrite high, SHALL latch address, write data and op; go to WAIT if WAIT_STATES>0, else RESP.
REQ-014 WAIT: SHALL load a down-counter with WAIT_STATES-1 on entry, decrement each cycle, go to RESP when it reads 0.
REQ-015 RESP: SHALL assert DataReady for exactly one cycle, then return to IDLE unconditionally.
REQ-016 Latency SHALL be WAIT_STATES+1 cycles from the sampling edge in IDLE to the DataReady-high cycle.
REQ-017 Request inputs SHALL be ignored in WAIT and RESP; a new request SHALL be sampled no earlier than the cycle after RESP.
REQ-018 DataRead and DataWrite both high in IDLE SHALL run a normal cycle with no RAM access, DataError=1, and DataIn unchanged.
REQ-019 Read: DataIn SHALL be loaded from RAM[addr] on the edge entering RESP and hold until the next read response.
REQ-020 Write: RAM[addr] SHALL be updated with latched data on the edge leaving RESP; DataIn unchanged.
REQ-021 Address >= DEPTH (outside MMIO) SHALL complete with normal timing and DataError=1; a read returns 0, a write is dropped.
REQ-022 Write then read of the same address SHALL return the written value.

Reset
REQ-023 Reset SHALL force IDLE, with DataIn=0, DataReady=0, DataError=0, and the wait counter at 0.
REQ-024 Reset mid-operation SHALL abandon the request with no RAM write committed; RAM contents SHALL NOT be cleared.

Configuration
REQ-025 Macro DMEM_CYCLE_COUNTER_EN defined: SHALL provide a 32-bit free-running counter at address 32'hFFFF_FFF0; it resets to 0, increments every cycle, and wraps 32'hFFFF_FFFF to 0.
REQ-026 Counter read SHALL return its value at the edge entering RESP; a counter write SHALL load the data, and the counter resumes incrementing the next cycle.
REQ-027 Macro undefined: SHALL omit the counter logic, and 32'hFFFF_FFF0 SHALL behave as out-of-range per REQ-021.

Verification
REQ-028 WAIT_STATES=1: write 32'hDEADBEEF to addr 5 -> DataReady 2 cycles after request, DataError=0; read addr 5 -> DataIn=32'hDEADBEEF at DataReady.
REQ-029 WAIT_STATES=0: back-to-back reads of addrs 0 and 1 -> each DataReady 1 cycle after sampling, with one IDLE cycle between responses.
REQ-030 Read addr 256 (DEPTH=256) -> DataReady=1, DataError=1, DataIn=0; write to addr 300 -> RAM unchanged.
REQ-031 DataRead=DataWrite=1 -> DataError=1, DataIn keeps its previous value, no RAM change.
REQ-032 Reset asserted during WAIT of a write to addr 7 -> IDLE next cycle, DataReady=0, and a subsequent read of addr 7 returns its old value.
REQ-033 DMEM_CYCLE_COUNTER_EN: write 32'hFFFF_FFFE to 32'hFFFF_FFF0, then read it -> value reflects wrap through 0; without macro -> DataError=1.
